// File: rtl/arm_shift_pipe.sv
// ARM operand-2 barrel shifter with carry-out, pipelined over LATENCY register stages.
// Stage 0 registers the request fields; the shifter result is then carried through the remaining stages.
module arm_shift_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rm_data,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       shift_amt,
  input  logic             shift_reg,
  input  logic             imm_mode,
  input  logic [7:0]       imm_val,
  input  logic [3:0]       rot_imm,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             carry_out
);

  localparam int LW = $clog2(WIDTH);
  localparam int AW = (LW + 1 > 9) ? LW + 1 : 9;
  localparam int RS = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam logic [AW-1:0] W_A = AW'(WIDTH);

  logic             adv;
  logic             f_valid;
  logic [WIDTH-1:0] f_rm;
  logic [1:0]       f_type;
  logic [7:0]       f_amt;
  logic             f_reg;
  logic             f_imm;
  logic [7:0]       f_immv;
  logic [3:0]       f_rot;
  logic             f_cin;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // A single-stage pipe computes straight from the ports into the output register.
  generate
    if (LATENCY == 1) begin : g_direct
      assign f_valid = in_valid;
      assign f_rm    = rm_data;
      assign f_type  = shift_type;
      assign f_amt   = shift_amt;
      assign f_reg   = shift_reg;
      assign f_imm   = imm_mode;
      assign f_immv  = imm_val;
      assign f_rot   = rot_imm;
      assign f_cin   = carry_in;
    end else begin : g_stage0
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          f_valid <= 1'b0;
          f_rm    <= '0;
          f_type  <= '0;
          f_amt   <= '0;
          f_reg   <= 1'b0;
          f_imm   <= 1'b0;
          f_immv  <= '0;
          f_rot   <= '0;
          f_cin   <= 1'b0;
        end else if (adv) begin
          f_valid <= in_valid;
          f_rm    <= rm_data;
          f_type  <= shift_type;
          f_amt   <= shift_amt;
          f_reg   <= shift_reg;
          f_imm   <= imm_mode;
          f_immv  <= imm_val;
          f_rot   <= rot_imm;
          f_cin   <= carry_in;
        end
      end
    end
  endgenerate

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [LW-1:0] r);
    logic [LW:0] s;
    s = (LW + 1)'(WIDTH) - {1'b0, r};
    return (v >> r) | (v << s);
  endfunction

  logic [AW-1:0]           n;
  logic [LW-1:0]           nl;
  logic [LW-1:0]           nl_neg;
  logic [LW-1:0]           nl_m1;
  logic [LW-1:0]           r_imm;
  logic signed [WIDTH-1:0] xs;
  logic [WIDTH-1:0]        res;
  logic                    res_c;

  // Immediate LSR/ASR #0 encode a full-width shift; ROR #0 (n stays 0) is RRX.
  always_comb begin
    xs     = f_rm;
    r_imm  = LW'({f_rot, 1'b0});
    if (f_reg)
      n = {{(AW-8){1'b0}}, f_amt};
    else if (f_amt[4:0] == 5'd0 && (f_type == 2'b01 || f_type == 2'b10))
      n = W_A;
    else
      n = {{(AW-5){1'b0}}, f_amt[4:0]};
    nl     = n[LW-1:0];
    nl_neg = '0 - nl;
    nl_m1  = nl - LW'(1);
    res    = f_rm;
    res_c  = f_cin;
    if (f_imm) begin
      res   = rotr({{(WIDTH-8){1'b0}}, f_immv}, r_imm);
      res_c = (f_rot == 4'd0) ? f_cin : res[WIDTH-1];
    end else if (n == '0) begin
      if (f_type == 2'b11 && !f_reg) begin
        res   = {f_cin, f_rm[WIDTH-1:1]};
        res_c = f_rm[0];
      end
    end else begin
      case (f_type)
        2'b00: begin
          if (n < W_A) begin
            res   = f_rm << nl;
            res_c = f_rm[nl_neg];
          end else begin
            res   = '0;
            res_c = (n == W_A) ? f_rm[0] : 1'b0;
          end
        end
        2'b01: begin
          if (n < W_A) begin
            res   = f_rm >> nl;
            res_c = f_rm[nl_m1];
          end else begin
            res   = '0;
            res_c = (n == W_A) ? f_rm[WIDTH-1] : 1'b0;
          end
        end
        2'b10: begin
          if (n < W_A) begin
            res   = xs >>> nl;
            res_c = f_rm[nl_m1];
          end else begin
            res   = {WIDTH{f_rm[WIDTH-1]}};
            res_c = f_rm[WIDTH-1];
          end
        end
        default: begin
          if (nl == '0) begin
            res   = f_rm;
            res_c = f_rm[WIDTH-1];
          end else begin
            res   = rotr(f_rm, nl);
            res_c = res[WIDTH-1];
          end
        end
      endcase
    end
  end

  logic [WIDTH-1:0] p_data  [RS];
  logic             p_carry [RS];
  logic             p_valid [RS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS; i++) begin
        p_data[i]  <= '0;
        p_carry[i] <= 1'b0;
        p_valid[i] <= 1'b0;
      end
    end else if (adv) begin
      p_data[0]  <= res;
      p_carry[0] <= res_c;
      p_valid[0] <= f_valid;
      for (int i = 1; i < RS; i++) begin
        p_data[i]  <= p_data[i-1];
        p_carry[i] <= p_carry[i-1];
        p_valid[i] <= p_valid[i-1];
      end
    end
  end

  assign out_valid = p_valid[RS-1];
  assign out_data  = p_data[RS-1];
  assign carry_out = p_carry[RS-1];

endmodule
